mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit for the 16-bit microRISC pipeline.
- Sits between the EX/MEM pipeline register and mem_wb_reg, and produces the mem_* bundle that mem_wb_reg captures.
- Drives a req/ack data-memory bus with variable wait states and a timeout.
- Stalls the upstream pipeline while an access is outstanding.

Parameters:
TIMEOUT, 15, max ACCESS cycles without dmem_ack before abort (1..255)
CNT_W, 8, width of wait-cycle counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_mem_read  input  1  load in EX/MEM
ex_mem_write  input  1  store in EX/MEM
ex_reg_write  input  1  register write enable from EX/MEM
ex_mem_to_reg  input  1  WB mux select from EX/MEM
ex_alu_result  input  16  ALU result / effective address
ex_write_data  input  16  store data
ex_write_reg  input  3  destination register
mem_reg_write  output  1  to mem_wb_reg
mem_mem_to_reg  output  1  to mem_wb_reg
mem_alu_result  output  16  to mem_wb_reg
mem_read_data  output  16  to mem_wb_reg
mem_write_reg  output  3  to mem_wb_reg
mem_stall  output  1  freeze PC/IF/ID/EX/MEM registers
mem_bus_err  output  1  one-cycle pulse: access timed out
dmem_req  output  1  bus request
dmem_we  output  1  1=write, 0=read
dmem_addr  output  16  word address
dmem_wdata  output  16  write data
dmem_ack  input  1  bus completion, 1 cycle
dmem_rdata  input  16  read data, valid with dmem_ack

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - rdata_q=0, counter=0, err flag=0.
  - All mem_* outputs read 0; mem_stall=0; mem_bus_err=0.
  - An outstanding request is dropped immediately.
- Access = ex_mem_read | ex_mem_write. If both are set, treat as a store.
- IDLE, no access:
  - mem_* = ex_* combinationally; mem_read_data=0; mem_stall=0.
  - Zero-latency pass-through.
- IDLE, access:
  - mem_stall=1 combinationally; mem_reg_write forced 0 (bubble into WB).
  - Latch address, data, we and controls into dmem_* registers, which take effect next cycle.
  - Next state ACCESS; counter cleared.
- ACCESS:
  - dmem_req=1, with dmem_addr, dmem_we and dmem_wdata held stable until ack.
  - mem_stall=1; mem_reg_write=0.
  - dmem_ack=1: capture dmem_rdata into rdata_q (loads only), drop dmem_req next cycle, go to DONE.
  - No ack: counter++. At counter==TIMEOUT-1 with no ack, set err, drop req, go to DONE.
  - Ack in the same cycle as the timeout: ack wins, no error.
- DONE:
  - mem_stall=0.
  - mem_* driven from latched controls; mem_read_data=rdata_q.
  - On err: mem_bus_err=1, mem_reg_write=0, mem_read_data=0.
  - mem_wb_reg samples at the end of this cycle; the EX/MEM register advances simultaneously.
  - Next state IDLE unconditionally. The held instruction is not re-triggered.
- Latency:
  - Zero-wait load (ack in first ACCESS cycle) takes 3 cycles in MEM.
  - Each wait state adds 1 cycle.
  - Timeout path takes TIMEOUT+2 cycles.
- dmem_ack outside ACCESS is ignored. rdata_q keeps its last value, which is visible only in DONE.
- dmem_addr = ex_alu_result (word-addressed memory, no byte lanes).
- State encoding: 2-bit, IDLE=0, ACCESS=1, DONE=2. Value 3 recovers to IDLE.

Decomposition:
- defines.v additions: MAU_IDLE, MAU_ACCESS, MAU_DONE state codes; MAU_TIMEOUT_DEFAULT.
- Sub-module mau_wait_counter: CNT_W counter with clear, enable and expire at TIMEOUT-1.
- The rest stays in a single FSM module.

Test Plan:
- Reset: assert rst_n=0 during ACCESS -> dmem_req=0 within 1ns, all mem_*=0, mem_stall=0, state IDLE.
- Pass-through: ex_reg_write=1, ex_alu_result=16'hABCD, ex_write_reg=3'b101, no mem op -> same values on mem_* in the same cycle, mem_stall=0.
- Zero-wait load:
  - Stimulus: ex_mem_read=1, ex_alu_result=16'h0040; bench acks the first req with dmem_rdata=16'h1234.
  - Response: mem_stall high for 2 cycles; then DONE with mem_read_data=16'h1234, mem_mem_to_reg=1, mem_reg_write=1.
- Wait-state store:
  - Stimulus: ex_mem_write=1, addr 16'h0100, data 16'h5A5A; ack after 4 cycles.
  - Response: dmem_we=1 and addr/wdata stable throughout; mem_stall high for 6 cycles; no mem_bus_err.
- Timeout: load with no ack -> mem_bus_err pulse of exactly 1 cycle after TIMEOUT+1 stalled cycles, mem_reg_write=0, mem_read_data=0, dmem_req deasserted.
- Back-to-back load then load, plus a spurious ack in IDLE -> two separate req cycles, spurious ack ignored, each result appears in its own DONE cycle.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared state codes and defaults for the MEM-stage load/store unit.
// The FSM state encoding is fixed at 2 bits so the unused value 3 can be recovered.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ACCESS = 2'd1,
    MAU_DONE   = 2'd2
  } mau_state_e;

  localparam int MAU_TIMEOUT_DEFAULT = 15;
  localparam int MAU_CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/mem_access_unit_wait_counter.sv
// Wait-cycle counter for outstanding bus accesses.
// The expire flag is raised while the count sits at TIMEOUT-1.
module mau_wait_counter
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = MAU_TIMEOUT_DEFAULT,
  parameter int CNT_W   = MAU_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: passes non-memory instructions straight through and runs
// loads/stores over a req/ack bus with wait states and a timeout, stalling upstream meanwhile.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = MAU_TIMEOUT_DEFAULT,
  parameter int CNT_W   = MAU_CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_write_data,
  input  logic [2:0]  ex_write_reg,
  output logic        mem_reg_write,
  output logic        mem_mem_to_reg,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_read_data,
  output logic [2:0]  mem_write_reg,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata
);

  mau_state_e  state, state_nxt;
  logic        access;
  logic        start, ack_hit, timeout;
  logic        cnt_clear, cnt_en, expire;
  logic        lat_reg_write, lat_mem_to_reg, lat_load;
  logic [2:0]  lat_write_reg;
  logic [15:0] rdata_q;
  logic        err;

  assign access = ex_mem_read | ex_mem_write;

  mau_wait_counter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MAU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = MAU_IDLE;
    start          = 1'b0;
    ack_hit        = 1'b0;
    timeout        = 1'b0;
    cnt_clear      = 1'b0;
    cnt_en         = 1'b0;
    mem_reg_write  = 1'b0;
    mem_mem_to_reg = 1'b0;
    mem_alu_result = '0;
    mem_read_data  = '0;
    mem_write_reg  = '0;
    mem_stall      = 1'b0;
    mem_bus_err    = 1'b0;
    case (state)
      MAU_IDLE: begin
        mem_mem_to_reg = ex_mem_to_reg;
        mem_alu_result = ex_alu_result;
        mem_write_reg  = ex_write_reg;
        if (access) begin
          // Bubble into WB while the access is launched
          start     = 1'b1;
          cnt_clear = 1'b1;
          mem_stall = 1'b1;
          state_nxt = MAU_ACCESS;
        end else begin
          mem_reg_write = ex_reg_write;
        end
      end
      MAU_ACCESS: begin
        mem_stall      = 1'b1;
        mem_mem_to_reg = lat_mem_to_reg;
        mem_alu_result = dmem_addr;
        mem_write_reg  = lat_write_reg;
        // An ack on the expiring cycle still completes normally
        if (dmem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = MAU_DONE;
        end else if (expire) begin
          timeout   = 1'b1;
          state_nxt = MAU_DONE;
        end else begin
          cnt_en    = 1'b1;
          state_nxt = MAU_ACCESS;
        end
      end
      MAU_DONE: begin
        mem_mem_to_reg = lat_mem_to_reg;
        mem_alu_result = dmem_addr;
        mem_write_reg  = lat_write_reg;
        mem_reg_write  = lat_reg_write & ~err;
        mem_read_data  = err ? 16'h0000 : rdata_q;
        mem_bus_err    = err;
        state_nxt      = MAU_IDLE;
      end
      default: state_nxt = MAU_IDLE;
    endcase
    // The pass-through path must not leak EX values while reset is held
    if (!rst_n) begin
      mem_reg_write  = 1'b0;
      mem_mem_to_reg = 1'b0;
      mem_alu_result = '0;
      mem_read_data  = '0;
      mem_write_reg  = '0;
      mem_stall      = 1'b0;
      mem_bus_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      rdata_q        <= '0;
      err            <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_load       <= 1'b0;
      lat_write_reg  <= '0;
    end else begin
      if (start) begin
        dmem_req       <= 1'b1;
        dmem_we        <= ex_mem_write;
        dmem_addr      <= ex_alu_result;
        dmem_wdata     <= ex_write_data;
        lat_reg_write  <= ex_reg_write;
        lat_mem_to_reg <= ex_mem_to_reg;
        lat_write_reg  <= ex_write_reg;
        lat_load       <= ex_mem_read & ~ex_mem_write;
        err            <= 1'b0;
      end
      if (ack_hit) begin
        dmem_req <= 1'b0;
        if (lat_load) rdata_q <= dmem_rdata;
      end
      if (timeout) begin
        dmem_req <= 1'b0;
        err      <= 1'b1;
      end
      if (state == MAU_DONE) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: combinational pass-through table plus
// hand-written load/store, wait-state, timeout, back-to-back and async-reset sequences.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [15:0] ex_alu_result, ex_write_data;
  logic [2:0]  ex_write_reg;
  logic        mem_reg_write, mem_mem_to_reg;
  logic [15:0] mem_alu_result, mem_read_data;
  logic [2:0]  mem_write_reg;
  logic        mem_stall, mem_bus_err;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls;

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [15:0] alu;
    logic [2:0]  wreg;
    logic        e_rw, e_m2r;
    logic [15:0] e_alu;
    logic [2:0]  e_wreg;
    logic        e_stall;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_alu_result (ex_alu_result),
    .ex_write_data (ex_write_data),
    .ex_write_reg  (ex_write_reg),
    .mem_reg_write (mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg),
    .mem_alu_result(mem_alu_result),
    .mem_read_data (mem_read_data),
    .mem_write_reg (mem_write_reg),
    .mem_stall     (mem_stall),
    .mem_bus_err   (mem_bus_err),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ex(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [15:0] alu, input logic [15:0] wd, input logic [2:0] wreg);
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
    ex_alu_result = alu;
    ex_write_data = wd;
    ex_write_reg  = wreg;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hABCD, 3'd5, 1'b1, 1'b0, 16'hABCD, 3'd5, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 3'd7, 1'b1, 1'b1, 16'hFFFF, 3'd7, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 3'd2, 1'b0, 1'b1, 16'h0040, 3'd2, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 3'd0, 1'b0, 1'b0, 16'h0100, 3'd0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h1357, 3'd6, 1'b0, 1'b0, 16'h1357, 3'd6, 1'b1};

    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0000;
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);

    // Reset state
    settle();
    settle();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", 32'(dmem_addr), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_err", 32'(mem_bus_err), 32'd0);
    chk("rst_rw", 32'(mem_reg_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational IDLE behaviour; access is withdrawn before the clock edge
    for (int i = 0; i < 6; i++) begin
      settle();
      set_ex(vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].m2r, vecs[i].alu, 16'h0, vecs[i].wreg);
      #1;
      chk($sformatf("vec%0d_rw", i), 32'(mem_reg_write), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d_m2r", i), 32'(mem_mem_to_reg), 32'(vecs[i].e_m2r));
      chk($sformatf("vec%0d_alu", i), 32'(mem_alu_result), 32'(vecs[i].e_alu));
      chk($sformatf("vec%0d_wreg", i), 32'(mem_write_reg), 32'(vecs[i].e_wreg));
      chk($sformatf("vec%0d_rdata", i), 32'(mem_read_data), 32'd0);
      chk($sformatf("vec%0d_stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
      #1;
      set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
    end

    // Zero-wait load
    settle();
    set_ex(1, 0, 1, 1, 16'h0040, 16'h0, 3'd3);
    #1;
    chk("zl_idle_stall", 32'(mem_stall), 32'd1);
    chk("zl_idle_req", 32'(dmem_req), 32'd0);
    settle();
    chk("zl_acc_req", 32'(dmem_req), 32'd1);
    chk("zl_acc_addr", 32'(dmem_addr), 32'h0040);
    chk("zl_acc_we", 32'(dmem_we), 32'd0);
    chk("zl_acc_stall", 32'(mem_stall), 32'd1);
    chk("zl_acc_rw", 32'(mem_reg_write), 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 16'h1234;
    settle();
    dmem_ack = 1'b0;
    chk("zl_done_stall", 32'(mem_stall), 32'd0);
    chk("zl_done_rdata", 32'(mem_read_data), 32'h1234);
    chk("zl_done_m2r", 32'(mem_mem_to_reg), 32'd1);
    chk("zl_done_rw", 32'(mem_reg_write), 32'd1);
    chk("zl_done_wreg", 32'(mem_write_reg), 32'd3);
    chk("zl_done_req", 32'(dmem_req), 32'd0);
    chk("zl_done_err", 32'(mem_bus_err), 32'd0);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);

    // Store acknowledged after four wait states
    settle();
    set_ex(0, 1, 0, 0, 16'h0100, 16'h5A5A, 3'd0);
    #1;
    chk("ws_idle_stall", 32'(mem_stall), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      settle();
      dmem_ack = (i == 5);
      #1;
      chk($sformatf("ws_c%0d_req", i), 32'(dmem_req), 32'd1);
      chk($sformatf("ws_c%0d_we", i), 32'(dmem_we), 32'd1);
      chk($sformatf("ws_c%0d_addr", i), 32'(dmem_addr), 32'h0100);
      chk($sformatf("ws_c%0d_wdata", i), 32'(dmem_wdata), 32'h5A5A);
      chk($sformatf("ws_c%0d_stall", i), 32'(mem_stall), 32'd1);
    end
    settle();
    dmem_ack = 1'b0;
    chk("ws_done_stall", 32'(mem_stall), 32'd0);
    chk("ws_done_err", 32'(mem_bus_err), 32'd0);
    chk("ws_done_req", 32'(dmem_req), 32'd0);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);

    // Load that is never acknowledged
    settle();
    set_ex(1, 0, 1, 1, 16'h0200, 16'h0, 3'd1);
    #1;
    stalls = 0;
    for (int g = 0; g < 40 && mem_stall; g++) begin
      stalls++;
      settle();
    end
    chk("to_stall_cycles", 32'(stalls), 32'(TIMEOUT + 1));
    chk("to_done_err", 32'(mem_bus_err), 32'd1);
    chk("to_done_rw", 32'(mem_reg_write), 32'd0);
    chk("to_done_rdata", 32'(mem_read_data), 32'd0);
    chk("to_done_req", 32'(dmem_req), 32'd0);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("to_err_pulse_end", 32'(mem_bus_err), 32'd0);

    // Ack arriving on the last allowed cycle beats the timeout
    set_ex(1, 0, 1, 1, 16'h0030, 16'h0, 3'd4);
    for (int i = 1; i <= TIMEOUT; i++) begin
      settle();
      dmem_ack = (i == TIMEOUT);
      dmem_rdata = 16'h7777;
    end
    settle();
    dmem_ack = 1'b0;
    chk("at_done_err", 32'(mem_bus_err), 32'd0);
    chk("at_done_rdata", 32'(mem_read_data), 32'h7777);
    chk("at_done_rw", 32'(mem_reg_write), 32'd1);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);

    // Back-to-back loads with a spurious ack in between
    settle();
    set_ex(1, 0, 1, 1, 16'h0010, 16'h0, 3'd2);
    settle();
    chk("bb1_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 16'hAAAA;
    settle();
    dmem_ack = 1'b0;
    chk("bb1_rdata", 32'(mem_read_data), 32'hAAAA);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
    settle();
    dmem_ack = 1'b1;
    dmem_rdata = 16'hDEAD;
    #1;
    chk("bb_spur_req", 32'(dmem_req), 32'd0);
    chk("bb_spur_stall", 32'(mem_stall), 32'd0);
    settle();
    dmem_ack = 1'b0;
    chk("bb_spur_ignored", 32'(dmem_req), 32'd0);
    set_ex(1, 0, 1, 1, 16'h0020, 16'h0, 3'd6);
    settle();
    chk("bb2_req", 32'(dmem_req), 32'd1);
    chk("bb2_addr", 32'(dmem_addr), 32'h0020);
    dmem_ack = 1'b1;
    dmem_rdata = 16'hBBBB;
    settle();
    dmem_ack = 1'b0;
    chk("bb2_rdata", 32'(mem_read_data), 32'hBBBB);
    chk("bb2_wreg", 32'(mem_write_reg), 32'd6);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);

    // Asynchronous reset while a request is outstanding
    settle();
    set_ex(1, 0, 1, 1, 16'h0050, 16'h0, 3'd7);
    settle();
    chk("ar_req_before", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(dmem_req), 32'd0);
    chk("ar_addr", 32'(dmem_addr), 32'd0);
    chk("ar_stall", 32'(mem_stall), 32'd0);
    chk("ar_rw", 32'(mem_reg_write), 32'd0);
    chk("ar_m2r", 32'(mem_mem_to_reg), 32'd0);
    chk("ar_alu", 32'(mem_alu_result), 32'd0);
    chk("ar_wreg", 32'(mem_write_reg), 32'd0);
    set_ex(0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    set_ex(0, 0, 1, 0, 16'h1111, 16'h0, 3'd1);
    #1;
    chk("ar_post_alu", 32'(mem_alu_result), 32'h1111);
    chk("ar_post_rw", 32'(mem_reg_write), 32'd1);
    chk("ar_post_stall", 32'(mem_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
